// File: rtl/ir_prefetch_queue_pkg.sv
// rtl/ir_prefetch_queue_pkg.sv - shared IR field bounds, opcode constants and entry width
// Purpose: constants shared by the prefetch queue and the instruction register.
// Ports: none (package).
package ir_prefetch_queue_pkg;

  // IR field bounds, bit 0 is the MSB as on the DBUS
  localparam int OP_L = 0;
  localparam int OP_R = 8;
  localparam int AC_L = 9;
  localparam int AC_R = 12;
  localparam int I_BIT = 13;
  localparam int X_L = 14;
  localparam int X_R = 17;
  localparam int IR_W = 18;

  // queue entry: 36-bit word followed by its prevEN flag
  localparam int WORD_W = 36;
  localparam int ENTRY_W = 37;
  localparam int PREV_BIT = 36;

  localparam logic [8:0] IR_OP_JRST = 9'o254;

  function automatic logic op_ac_match(input logic [0:IR_W-1] ir,
                                       input logic [8:0] op,
                                       input logic [3:0] ac);
    return (ir[OP_L:OP_R] == op) && (ir[AC_L:AC_R] == ac);
  endfunction

endpackage

// File: rtl/ir_prefetch_queue_fifo.sv
// rtl/ir_prefetch_queue_fifo.sv - circular prefetch buffer with count, status and sticky overflow
// Purpose: DEPTH-entry circular buffer of 37-bit entries (module ir_fifo).
// Ports:
//   clk, rst (async active-low), clken  - clock, reset, clock enable
//   push, din                            - push request and entry
//   pop                                  - pop request (ignored when empty)
//   flush                                - empty the queue, clear ovf, discard push
//   head                                 - entry at read pointer (stale when empty)
//   count, empty, full, ovf              - occupancy and status
module ir_fifo
  import ir_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clken,
  input  logic                      push,
  input  logic [0:ENTRY_W-1]        din,
  input  logic                      pop,
  input  logic                      flush,
  output logic [0:ENTRY_W-1]        head,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full,
  output logic                      ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [0:ENTRY_W-1] mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic               pop_ok;
  logic               push_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rptr];

  // a pop frees the slot this same cycle, so a full queue still accepts a push
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;

  always_ff @(posedge clk) begin
    if (clken && push_ok) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clken) begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end else begin
        if (push_ok) begin
          wptr <= wptr + AW'(1);
        end
        if (pop_ok) begin
          rptr <= rptr + AW'(1);
        end
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        if (push && !push_ok) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ir_prefetch_queue.sv
// rtl/ir_prefetch_queue.sv - instruction register with split loading fed by DBUS or a prefetch queue
// Purpose: 18-bit IR (opcode/AC/I/X) loaded from DBUS or the queue head, with
//          stall detection and JRST 0 / parametrised opcode decode.
// Ports:
//   clk, rst (async active-low), clken   - clock, reset, clock enable
//   dbus[0:35], prevEN                   - datapath word and its previous-context flag
//   pfWR, flush                          - queue push, queue discard
//   loadIR, loadXR, useQ                 - IR[0:12] strobe, IR[13:17]+xrPREV strobe, source select
//   regIR[0:17], xrPREV                  - instruction register
//   JRST0, opMATCH                       - decode outputs
//   count, empty, full, ovf, stall       - queue status
module ir_prefetch_queue
  import ir_prefetch_queue_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [8:0] MATCH_OP = 9'o254,
  parameter logic [3:0] MATCH_AC = 4'o0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clken,
  input  logic [0:WORD_W-1]      dbus,
  input  logic                   prevEN,
  input  logic                   pfWR,
  input  logic                   flush,
  input  logic                   loadIR,
  input  logic                   loadXR,
  input  logic                   useQ,
  output logic [0:IR_W-1]        regIR,
  output logic                   xrPREV,
  output logic                   JRST0,
  output logic                   opMATCH,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf,
  output logic                   stall
);

  logic [0:ENTRY_W-1] head;
  logic [0:IR_W-1]    src_ir;
  logic               src_prev;
  logic               unused_head_bits;

  ir_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clken(clken),
    .push (pfWR),
    .din  ({dbus, prevEN}),
    // loadIR alone only peeks, so a split load consumes one entry
    .pop  (loadXR & useQ),
    .flush(flush),
    .head (head),
    .count(count),
    .empty(empty),
    .full (full),
    .ovf  (ovf)
  );

  // the right half of a queued word is not part of the IR
  assign unused_head_bits = ^head[IR_W:WORD_W-1];

  assign src_ir   = useQ ? head[0:IR_W-1] : dbus[0:IR_W-1];
  assign src_prev = useQ ? head[PREV_BIT] : prevEN;

  assign stall = useQ & (loadIR | loadXR) & empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regIR  <= '0;
      xrPREV <= 1'b0;
    end else if (clken && !stall) begin
      if (loadIR) begin
        regIR[OP_L:AC_R] <= src_ir[OP_L:AC_R];
      end
      if (loadXR) begin
        regIR[I_BIT:X_R] <= src_ir[I_BIT:X_R];
        xrPREV           <= src_prev;
      end
    end
  end

  assign JRST0   = op_ac_match(regIR, IR_OP_JRST, 4'o0);
  assign opMATCH = op_ac_match(regIR, MATCH_OP, MATCH_AC);

endmodule
